// File: rtl/piso_pkg.sv
// Shared types and defaults for the parallel-in / serial-out shifter.
package piso_pkg;

    // Two-state controller: waiting for a word, or streaming one out.
    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam int DEF_WIDTH     = 8;
    localparam int DEF_MSB_FIRST = 1;

endpackage

// File: rtl/piso_param.sv
// Parameterized parallel-in / serial-out shifter with load handshake,
// shift stall and back-to-back word chaining.
module piso_param
    import piso_pkg::*;
#(
    parameter int WIDTH     = DEF_WIDTH,
    parameter int MSB_FIRST = DEF_MSB_FIRST
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] pin,
    input  logic             shift_en,
    output logic             ready,
    output logic             sout,
    output logic             sout_valid,
    output logic             last
);

    localparam int CW = $clog2(WIDTH);

    state_t           state, state_nxt;
    logic [WIDTH-1:0] sreg;
    logic [CW-1:0]    cnt;
    logic             cnt_zero;
    logic             accept;

    assign cnt_zero = (cnt == '0);

    // A new word fits when idle, or when the final bit leaves on this edge.
    assign ready  = (state == IDLE) || (cnt_zero && shift_en);
    assign accept = load && ready;

    // Serial bit comes straight from the register; it is zero while idle
    // because the register is cleared on the way back to IDLE.
    assign sout       = (MSB_FIRST != 0) ? sreg[WIDTH-1] : sreg[0];
    assign sout_valid = (state == SHIFT);
    assign last       = (state == SHIFT) && cnt_zero;

    // State register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_nxt;
    end

    // Next-state: chain words on the final bit when a load is accepted.
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (accept) state_nxt = SHIFT;
            SHIFT: if (shift_en && cnt_zero) state_nxt = accept ? SHIFT : IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // Shift register and bit counter; both hold whenever shift_en is low.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sreg <= '0;
            cnt  <= '0;
        end else if (accept) begin
            sreg <= pin;
            cnt  <= CW'(WIDTH - 1);
        end else if (state == SHIFT && shift_en) begin
            if (!cnt_zero) begin
                sreg <= (MSB_FIRST != 0) ? {sreg[WIDTH-2:0], 1'b0}
                                         : {1'b0, sreg[WIDTH-1:1]};
                cnt  <= cnt - 1'b1;
            end else begin
                sreg <= '0;
            end
        end
    end

endmodule

// File: tb/tb_piso_param.sv
// Bench for piso_param: three instances (4-bit MSB-first, 4-bit LSB-first,
// 8-bit MSB-first) checked against a queue-of-pending-bits reference model.
module tb_piso_param;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       load = 1'b0;
    logic       shift_en = 1'b0;
    logic [3:0] pin4 = '0;
    logic [7:0] pin8 = '0;

    logic rdy [3];
    logic so  [3];
    logic sv  [3];
    logic lst [3];

    int n_chk  = 0;
    int n_fail = 0;

    // Reference: per instance, the bits still to appear on sout, front first.
    bit mq [3][$];
    int wid  [3] = '{4, 4, 8};
    int msbf [3] = '{1, 0, 1};

    always #5 clk = ~clk;

    piso_param #(.WIDTH(4), .MSB_FIRST(1)) u_m4 (
        .clk(clk), .rst(rst), .load(load), .pin(pin4), .shift_en(shift_en),
        .ready(rdy[0]), .sout(so[0]), .sout_valid(sv[0]), .last(lst[0]));

    piso_param #(.WIDTH(4), .MSB_FIRST(0)) u_l4 (
        .clk(clk), .rst(rst), .load(load), .pin(pin4), .shift_en(shift_en),
        .ready(rdy[1]), .sout(so[1]), .sout_valid(sv[1]), .last(lst[1]));

    piso_param #(.WIDTH(8), .MSB_FIRST(1)) u_m8 (
        .clk(clk), .rst(rst), .load(load), .pin(pin8), .shift_en(shift_en),
        .ready(rdy[2]), .sout(so[2]), .sout_valid(sv[2]), .last(lst[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit m_ready(int k, bit se);
        return (mq[k].size() == 0) || (mq[k].size() == 1 && se);
    endfunction

    task automatic check_all();
        for (int k = 0; k < 3; k++) begin
            bit busy = (mq[k].size() > 0);
            chk($sformatf("ready%0d", k), rdy[k], m_ready(k, shift_en));
            chk($sformatf("valid%0d", k), sv[k], busy);
            chk($sformatf("sout%0d", k),  so[k], busy ? mq[k][0] : 1'b0);
            chk($sformatf("last%0d", k),  lst[k], mq[k].size() == 1);
        end
    endtask

    task automatic m_edge();
        for (int k = 0; k < 3; k++) begin
            bit          rd = m_ready(k, shift_en);
            logic [31:0] pv = (k == 2) ? 32'(pin8) : 32'(pin4);
            if (mq[k].size() > 0 && shift_en) void'(mq[k].pop_front());
            if (load && rd)
                for (int i = 0; i < wid[k]; i++)
                    mq[k].push_back(msbf[k] != 0 ? pv[wid[k]-1-i] : pv[i]);
        end
    endtask

    // Called just after a rising edge: drive, check mid-cycle, advance model.
    task automatic cycle(input bit l, input logic [3:0] p4, input logic [7:0] p8, input bit se);
        load = l; pin4 = p4; pin8 = p8; shift_en = se;
        @(negedge clk);
        check_all();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    // Asynchronous reset pulse between edges, then a load on the very next edge.
    task automatic async_reset(input logic [3:0] p4, input logic [7:0] p8);
        @(negedge clk);
        #1 rst = 1'b0;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk($sformatf("rst_ready%0d", k), rdy[k], 1'b1);
            chk($sformatf("rst_valid%0d", k), sv[k], 1'b0);
            chk($sformatf("rst_sout%0d", k),  so[k], 1'b0);
            chk($sformatf("rst_last%0d", k),  lst[k], 1'b0);
            mq[k].delete();
        end
        #1 rst = 1'b1;
        load = 1'b1; pin4 = p4; pin8 = p8; shift_en = 1'b1;
        @(posedge clk);
        m_edge();
        #1;
    endtask

    initial begin
        #12 rst = 1'b1;
        @(posedge clk); #1;

        // Idle after reset.
        cycle(0, 4'h0, 8'h00, 1);

        // Single word 1010 / 0x96 with continuous shifting.
        cycle(1, 4'b1010, 8'h96, 1);
        repeat (9) cycle(0, 4'h0, 8'h00, 1);

        // Back-to-back: 1100 then 0011, load held on the final bit.
        cycle(1, 4'b1100, 8'hA5, 1);
        repeat (3) cycle(0, 4'h0, 8'h00, 1);
        cycle(1, 4'b0011, 8'hFF, 1);
        repeat (9) cycle(0, 4'h0, 8'h00, 1);

        // Stall after the 2nd bit; a load during the stall must be ignored.
        cycle(1, 4'b1010, 8'h3C, 1);
        cycle(0, 4'h0, 8'h00, 1);
        repeat (3) cycle(1, 4'b1111, 8'hFF, 0);
        repeat (9) cycle(0, 4'h0, 8'h00, 1);

        // Reset mid-word, then a fresh word on the first edge after release.
        cycle(1, 4'b0110, 8'hC3, 1);
        repeat (2) cycle(0, 4'h0, 8'h00, 1);
        async_reset(4'b1001, 8'h5A);
        repeat (9) cycle(0, 4'h0, 8'h00, 1);

        // Random traffic: loads at arbitrary times, shift_en mostly high.
        repeat (400)
            cycle(1'($urandom_range(0, 1)), 4'($urandom), 8'($urandom),
                  ($urandom_range(0, 3) != 0));
        repeat (12) cycle(0, 4'h0, 8'h00, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/piso_param.md
PISO_PARAM -- requirements
Module: piso_param

Interface
REQ-001 Parameter WIDTH, default 8, SHALL set the parallel word width (legal range 2..32).
REQ-002 Parameter MSB_FIRST, default 1, SHALL select serial order: 1 = bit WIDTH-1 first, 0 = bit 0 first.
REQ-003 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 rst  input  1  SHALL be the reset, asynchronous and active-low.
REQ-005 load  input  1  SHALL request capture of pin; a word is accepted only on a rising edge with load=1 and ready=1.
REQ-006 pin  input  WIDTH  SHALL be the parallel data word.
REQ-007 shift_en  input  1  SHALL advance the shift when 1 and stall all SHIFT-state activity when 0.
REQ-008 ready  output  1  SHALL indicate that a word can be accepted this cycle.
REQ-009 sout  output  1  SHALL be the current serial bit.
REQ-010 sout_valid  output  1  SHALL be 1 while sout carries a data bit.
REQ-011 last  output  1  SHALL be 1 while sout carries the final bit of a word.

Function
REQ-012 The FSM SHALL have exactly two states, IDLE and SHIFT.
REQ-013 In IDLE: ready=1, sout_valid=0, last=0, sout=0.
REQ-014 An accepted load SHALL capture pin into the shift register, set the bit counter to WIDTH-1 and enter SHIFT; pin is sampled only on acceptance.
REQ-015 Latency: the first serial bit SHALL appear on sout the cycle after acceptance (one clock).
REQ-016 In SHIFT: sout_valid=1; sout = register bit WIDTH-1 (MSB_FIRST=1) or bit 0 (MSB_FIRST=0), driven directly from a flop, with no combinational path from inputs.
REQ-017 On each edge in SHIFT with shift_en=1 and counter>0, the register SHALL shift one position toward the output end, filling with 0, and the counter SHALL decrement by 1.
REQ-018 With shift_en=0, register, counter and state SHALL hold; sout, sout_valid and last SHALL remain stable.
REQ-019 last SHALL be 1 in SHIFT when counter==0.
REQ-020 ready SHALL be 1 in SHIFT only when counter==0 and shift_en=1.
REQ-021 Counter==0 edge with shift_en=1 and load=1: the new word SHALL be loaded and the FSM SHALL stay in SHIFT, giving back-to-back words with no gap bit.
REQ-022 Counter==0 edge with shift_en=1 and load=0: the FSM SHALL return to IDLE.
REQ-023 A load while ready=0 SHALL be ignored and SHALL NOT corrupt the word in flight.
REQ-024 The counter width SHALL be $clog2(WIDTH); the counter SHALL never wrap below 0.

Reset
REQ-025 Asserting rst (low) SHALL immediately force state=IDLE, register=0, counter=0, sout=0, sout_valid=0, last=0, ready=1, including mid-word; the partial word is discarded.
REQ-026 After rst deasserts, the first rising edge SHALL already accept a load.

Structure
REQ-027 Package piso_pkg SHALL hold the state typedef (IDLE, SHIFT) and the default WIDTH/MSB_FIRST localparams.
REQ-028 The design SHALL be one module, with no sub-module; counter and shift register are inline.

Verification
REQ-029 WIDTH=4, MSB_FIRST=1, pin=1010, shift_en=1, one-cycle load -> sout 1,0,1,0 on the four following cycles, last high on the 4th only, then IDLE.
REQ-030 Same with MSB_FIRST=0 -> sout 0,1,0,1.
REQ-031 WIDTH=4, words 1100 then 0011, load held on the last cycle -> eight contiguous valid bits 1,1,0,0,0,0,1,1 with no gap, and ready high only on bits 4 and 8.
REQ-032 pin=1010, shift_en low for 3 cycles after the 2nd bit -> sout holds 0 for those cycles, then 1,0; a load with pin=1111 during the stall is ignored.
REQ-033 rst pulsed low asynchronously between clock edges during the 3rd bit -> outputs go to reset values immediately, before the next edge, and a load on the next edge after release outputs a correct fresh word.
REQ-034 WIDTH=8, pin=0x96, MSB_FIRST=1 -> sout 1,0,0,1,0,1,1,0.
